// File: rtl/clock_display.sv
// clock_display: six-digit multiplexed common-anode HH MM SS scanner; define CLOCK_DISPLAY_LZB_EN to blank a leading hour zero.
// Latency: an/seg are registered one clock after the scan index; hour/min/sec are snapshotted at every frame start.
// Backpressure: none; the scan free-runs and blank only gates the registered anodes/segments.
module clock_display #(
  parameter int SCAN_DIV = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] hour,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  input  logic       blank,
  output logic [5:0] an,
  output logic [6:0] seg
);
  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

  logic [15:0] divcnt;
  logic [2:0]  d;
  logic        started;
  logic [4:0]  hour_s;
  logic [5:0]  min_s;
  logic [5:0]  sec_s;
  logic        div_wrap;
  logic        frame_start;
  logic [3:0]  digit;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [3:0] tens(input logic [5:0] v);
    return 4'(v / 6'd10);
  endfunction

  function automatic logic [3:0] units(input logic [5:0] v);
    return 4'(v % 6'd10);
  endfunction

  assign div_wrap    = (divcnt == DIV_LAST);
  assign frame_start = !started || (div_wrap && d == 3'd5);

  // Digit selection reads only the snapshot, so a frame is always self-consistent.
  always_comb begin
    digit = 4'd0;
    case (d)
      3'd0:    digit = tens({1'b0, hour_s});
      3'd1:    digit = units({1'b0, hour_s});
      3'd2:    digit = tens(min_s);
      3'd3:    digit = units(min_s);
      3'd4:    digit = tens(sec_s);
      3'd5:    digit = units(sec_s);
      default: digit = 4'd0;
    endcase
`ifdef CLOCK_DISPLAY_LZB_EN
    if (d == 3'd0 && hour_s < 5'd10) digit = 4'd15;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      divcnt  <= '0;
      d       <= '0;
      started <= 1'b0;
      hour_s  <= '0;
      min_s   <= '0;
      sec_s   <= '0;
      an      <= 6'b111111;
      seg     <= 7'b1111111;
    end else begin
      if (frame_start) begin
        hour_s <= hour;
        min_s  <= min;
        sec_s  <= sec;
      end
      // The first cycle out of reset only loads the snapshot; scanning starts on the next.
      if (!started) begin
        started <= 1'b1;
      end else begin
        if (div_wrap) begin
          divcnt <= '0;
          d      <= (d == 3'd5) ? 3'd0 : d + 3'd1;
        end else begin
          divcnt <= divcnt + 16'd1;
        end
        an  <= blank ? 6'b111111 : ~(6'd1 << d);
        seg <= blank ? 7'b1111111 : decode(digit);
      end
    end
  end
endmodule

// File: tb/tb_clock_display.sv
// Directed bench for clock_display with SCAN_DIV=4; expected an/seg pairs go through a scoreboard queue.
module tb_clock_display;
  localparam int SD = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       blank;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic [5:0] an;
  logic [6:0] seg;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [5:0] an;
    logic [6:0] seg;
  } exp_t;
  exp_t sb[$];

  clock_display #(.SCAN_DIV(SD)) dut (
    .clock(clock),
    .reset(reset),
    .hour (hour),
    .min  (min),
    .sec  (sec),
    .blank(blank),
    .an   (an),
    .seg  (seg)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0:       return 7'b1000000;
      1:       return 7'b1111001;
      2:       return 7'b0100100;
      3:       return 7'b0110000;
      4:       return 7'b0011001;
      5:       return 7'b0010010;
      6:       return 7'b0000010;
      7:       return 7'b1111000;
      8:       return 7'b0000000;
      9:       return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Queue the expectation for the coming edge, then compare once the DUT has updated.
  task automatic cyc(input string tag, input logic [5:0] a, input logic [6:0] s);
    exp_t e;
    e.tag = tag;
    e.an  = a;
    e.seg = s;
    sb.push_back(e);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    checks++;
    assert (an === e.an && seg === e.seg)
    else begin
      errors++;
      $error("FAIL %s: an=%b seg=%b, expected an=%b seg=%b", e.tag, an, seg, e.an, e.seg);
    end
  endtask

  // One scan frame (or its first ncyc clocks) for a snapshot h:m:s, with optional blank window and input change.
  task automatic frame(input string tag, input int h, input int m, input int s, input int ncyc,
                       input int bl_from, input int bl_len,
                       input int chg_at, input int ch, input int cm, input int cs);
    int dig[6];
    logic [6:0] sx;
    dig[0] = h / 10;
    dig[1] = h % 10;
    dig[2] = m / 10;
    dig[3] = m % 10;
    dig[4] = s / 10;
    dig[5] = s % 10;
    for (int c = 0; c < ncyc; c++) begin
      int i;
      i = c / SD;
      blank = (c >= bl_from && c < bl_from + bl_len);
      if (c == chg_at) begin
        hour = 5'(ch);
        min  = 6'(cm);
        sec  = 6'(cs);
      end
      sx = seg_of(dig[i]);
`ifdef CLOCK_DISPLAY_LZB_EN
      if (i == 0 && h < 10) sx = 7'b1111111;
`endif
      if (blank) cyc($sformatf("%s[%0d]", tag, c), 6'b111111, 7'b1111111);
      else       cyc($sformatf("%s[%0d]", tag, c), ~(6'd1 << i), sx);
    end
    blank = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    blank = 1'b0;
    hour  = 5'd5;
    min   = 6'd29;
    sec   = 6'd3;

    for (int k = 0; k < 5; k++) cyc("reset_hold", 6'b111111, 7'b1111111);
    reset = 1'b0;
    cyc("startup_edge1", 6'b111111, 7'b1111111);

    frame("frame_05_29_03", 5, 29, 3, 6 * SD, -1, 0, -1, 0, 0, 0);
    // sec changes while digit 2 is being scanned; this frame must still show 3.
    frame("snapshot_old", 5, 29, 3, 6 * SD, -1, 0, 9, 5, 29, 4);
    frame("snapshot_new", 5, 29, 4, 6 * SD, -1, 0, 1, 31, 29, 63);
    // Out-of-range values, with blank held for 6 clocks starting mid-digit-3.
    frame("range_blank", 31, 29, 63, 6 * SD, 13, 6, -1, 0, 0, 0);

    // Stop once digit 4 is on the display, then pulse reset for one clock.
    frame("pre_reset", 31, 29, 63, 4 * SD + 1, -1, 0, 2, 7, 45, 8);
    reset = 1'b1;
    cyc("midframe_reset", 6'b111111, 7'b1111111);
    reset = 1'b0;
    cyc("restart_edge1", 6'b111111, 7'b1111111);
    frame("restart_07", 7, 45, 8, 6 * SD, -1, 0, 0, 12, 45, 8);
    frame("hour_12", 12, 45, 8, 6 * SD, -1, 0, -1, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
